ws2812_frame_ctrl: RTL and testbench



---
 rtl/ws2812_frame_ctrl.sv | 100 ++++++++++
 tb/tb_ws2812_frame_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame sequencer: holds a host-written GRB pixel buffer and feeds it to the
// RZ_Code encoder one word per load strobe, then holds the line idle for the latch gap.
module ws2812_frame_ctrl #(
  parameter int NUM_LEDS     = 8,
  parameter int ADDR_W       = 3,
  parameter int PIXEL_CYCLES = 1500,
  parameter int RESET_CYCLES = 2500,
  parameter int CNT_W        = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic [23:0]       rgb,
  output logic              load,
  output logic [ADDR_W-1:0] led_idx
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0]  SHIFT_END = CNT_W'(PIXEL_CYCLES - 2);
  localparam logic [CNT_W-1:0]  LATCH_END = CNT_W'(RESET_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [23:0]      pix_buf [2**ADDR_W];

  // Only the first NUM_LEDS entries are writable; higher addresses are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_buf <= '{default: '0};
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (wr_en && wr_addr == ADDR_W'(i)) pix_buf[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      load       <= 1'b0;
      rgb        <= '0;
      led_idx    <= '0;
      timer      <= '0;
    end else begin
      frame_done <= 1'b0;
      load       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            led_idx <= '0;
            rgb     <= pix_buf[0];
            load    <= 1'b1;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          timer <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          // Ending SHIFT one count early makes LOAD+SHIFT exactly PIXEL_CYCLES long.
          if (timer == SHIFT_END) begin
            if (led_idx < LAST_IDX) begin
              led_idx <= led_idx + 1'b1;
              rgb     <= pix_buf[led_idx + 1'b1];
              load    <= 1'b1;
              state   <= LOAD;
            end else begin
              timer <= '0;
              state <= LATCH;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        LATCH: begin
          if (timer == LATCH_END) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Directed bench for ws2812_frame_ctrl with a 3-pixel chain, 10-cycle pixels and 20-cycle latch gap.
module tb_ws2812_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [23:0] wr_data;
  logic        busy;
  logic        frame_done;
  logic [23:0] rgb;
  logic        load;
  logic [2:0]  led_idx;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  ws2812_frame_ctrl #(
    .NUM_LEDS(3), .ADDR_W(3), .PIXEL_CYCLES(10), .RESET_CYCLES(20), .CNT_W(12)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .frame_done(frame_done), .rgb(rgb),
    .load(load), .led_idx(led_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_px(input logic [2:0] a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Called at cycle 0 of a frame (the cycle after the accepting edge); returns at cycle 50.
  task automatic run_frame(input logic [23:0] e0, input logic [23:0] e1, input logic [23:0] e2,
                           input int wc1, input logic [2:0] wa1, input logic [23:0] wd1,
                           input int wc2, input logic [2:0] wa2, input logic [23:0] wd2,
                           input int s1, input int s2, input bit hold);
    logic [23:0] exp_rgb;
    for (int c = 0; c <= 50; c++) begin
      chk("load", {31'd0, load}, {31'd0, (c == 0 || c == 10 || c == 20)});
      chk("busy", {31'd0, busy}, {31'd0, (c < 50)});
      chk("frame_done", {31'd0, frame_done}, {31'd0, (c == 50)});
      if (c == 0 || c == 10 || c == 20) begin
        exp_rgb = (c == 0) ? e0 : (c == 10) ? e1 : e2;
        chk("rgb_at_load", {8'd0, rgb}, {8'd0, exp_rgb});
        chk("led_idx_at_load", {29'd0, led_idx}, c / 10);
      end
      if (c == 40) begin
        chk("rgb_held_latch", {8'd0, rgb}, {8'd0, e2});
        chk("led_idx_latch", {29'd0, led_idx}, 32'd2);
      end
      wr_en   = (c == wc1) || (c == wc2);
      wr_addr = (c == wc2) ? wa2 : wa1;
      wr_data = (c == wc2) ? wd2 : wd1;
      start   = hold || (c == s1) || (c == s2);
      if (c < 50) tick();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_load", {31'd0, load}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_rgb", {8'd0, rgb}, 32'd0);
    chk("rst_led_idx", {29'd0, led_idx}, 32'd0);
    rst = 1'b0;
    tick();

    write_px(3'd0, 24'hB9E40E);
    write_px(3'd1, 24'h0EB9E4);
    write_px(3'd2, 24'hFF00FF);
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Basic frame
    start = 1'b1; tick();
    run_frame(24'hB9E40E, 24'h0EB9E4, 24'hFF00FF, -1, 3'd0, 24'd0, -1, 3'd0, 24'd0, -1, -1, 1'b0);
    tick(); tick();

    // Starts during a busy frame are ignored
    start = 1'b1; tick();
    run_frame(24'hB9E40E, 24'h0EB9E4, 24'hFF00FF, -1, 3'd0, 24'd0, -1, 3'd0, 24'd0, 3, 30, 1'b0);
    tick();

    // Mid-frame writes: addr 1 lands before its load, addr 0 only on the next frame
    start = 1'b1; tick();
    run_frame(24'hB9E40E, 24'h123456, 24'hFF00FF, 5, 3'd1, 24'h123456, 15, 3'd0, 24'hAAAAAA, -1, -1, 1'b0);
    tick();

    // Out-of-range address must not disturb the buffer
    write_px(3'd5, 24'hDEADBE);
    start = 1'b1; tick();
    run_frame(24'hAAAAAA, 24'h123456, 24'hFF00FF, -1, 3'd0, 24'd0, -1, 3'd0, 24'd0, -1, -1, 1'b0);
    tick();

    // Start held high: back-to-back frames every 51 cycles
    start = 1'b1; tick();
    run_frame(24'hAAAAAA, 24'h123456, 24'hFF00FF, -1, 3'd0, 24'd0, -1, 3'd0, 24'd0, -1, -1, 1'b1);
    tick();
    run_frame(24'hAAAAAA, 24'h123456, 24'hFF00FF, -1, 3'd0, 24'd0, -1, 3'd0, 24'd0, -1, -1, 1'b1);
    tick();
    run_frame(24'hAAAAAA, 24'h123456, 24'hFF00FF, -1, 3'd0, 24'd0, -1, 3'd0, 24'd0, -1, -1, 1'b0);
    tick(); tick();

    // Asynchronous reset in the middle of SHIFT
    start = 1'b1; tick(); start = 1'b0;
    repeat (25) tick();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    chk("pre_rst_led_idx", {29'd0, led_idx}, 32'd2);
    chk("pre_rst_rgb", {8'd0, rgb}, {8'd0, 24'hFF00FF});
    rst = 1'b1;
    #2;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_load", {31'd0, load}, 32'd0);
    chk("async_rst_rgb", {8'd0, rgb}, 32'd0);
    chk("async_rst_led_idx", {29'd0, led_idx}, 32'd0);
    chk("async_rst_frame_done", {31'd0, frame_done}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Buffer was cleared by reset
    start = 1'b1; tick();
    run_frame(24'h000000, 24'h000000, 24'h000000, -1, 3'd0, 24'd0, -1, 3'd0, 24'd0, -1, -1, 1'b0);
    tick();
    chk("final_idle_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
